// File: rtl/vu_acc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vu_acc_pkg : shared types for the vector-unit accumulate lanes    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package vu_acc_pkg;

  localparam int ACC_W = 48;

  typedef enum logic [1:0] {
    VU_OP_NOP  = 2'b00,
    VU_OP_LOAD = 2'b01,
    VU_OP_ADD  = 2'b10,
    VU_OP_SUB  = 2'b11
  } vu_op_e;

  typedef enum logic [1:0] {
    VU_SEL_LO       = 2'b00,
    VU_SEL_MID      = 2'b01,
    VU_SEL_MIDCLAMP = 2'b10,
    VU_SEL_HI       = 2'b11
  } vu_sel_e;

endpackage
`default_nettype wire

// File: rtl/vu_clamp16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vu_clamp16 : combinational signed 32-to-16 saturating clamp       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module vu_clamp16 (
  input  logic [31:0] din,
  output logic [15:0] dout
);

  logic w_in_range;

  // Representable in s16 only when the top 17 bits are a pure sign extension.
  assign w_in_range = (&din[31:15]) | ~(|din[31:15]);
  assign dout       = w_in_range ? din[15:0] : (din[31] ? 16'h8000 : 16'h7FFF);

endmodule
`default_nettype wire

// File: rtl/vu_acc_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vu_acc_lane : two-stage 48-bit signed multiply-accumulate lane    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module vu_acc_lane #(
  parameter int ACC_W = 48
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [1:0]  op,
  input  logic [31:0] product,
  input  logic        align,
  input  logic [1:0]  sel,
  input  logic        ovf_clr,
  output logic [15:0] result,
  output logic        out_valid,
  output logic        acc_ovf
);

  import vu_acc_pkg::*;

  vu_op_e             r_s1_op;
  vu_sel_e            r_s1_sel;
  logic               r_s1_valid;
  logic [ACC_W-1:0]   r_s1_opnd;
  vu_sel_e            r_s2_sel;
  logic               r_s2_valid;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  logic [ACC_W-1:0]   w_opnd;
  logic [ACC_W-1:0]   w_sum;
  logic [ACC_W-1:0]   w_diff;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_ovf_evt;
  logic [15:0]        w_clamp;

  assign w_opnd = align ? {product, 16'h0000} : {{(ACC_W-32){product[31]}}, product};
  assign w_sum  = r_acc + r_s1_opnd;
  assign w_diff = r_acc - r_s1_opnd;

  // Overflow: result sign leaves the old acc sign when operand signs allow it.
  always_comb begin
    w_acc_next = r_acc;
    w_ovf_evt  = 1'b0;
    case (r_s1_op)
      VU_OP_LOAD: w_acc_next = r_s1_opnd;
      VU_OP_ADD: begin
        w_acc_next = w_sum;
        w_ovf_evt  = (r_acc[ACC_W-1] == r_s1_opnd[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
      end
      VU_OP_SUB: begin
        w_acc_next = w_diff;
        w_ovf_evt  = (r_acc[ACC_W-1] != r_s1_opnd[ACC_W-1]) &&
                     (w_diff[ACC_W-1] != r_acc[ACC_W-1]);
      end
      default: w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_s1_op    <= VU_OP_NOP;
      r_s1_sel   <= VU_SEL_LO;
      r_s1_valid <= 1'b0;
      r_s1_opnd  <= '0;
      r_s2_sel   <= VU_SEL_LO;
      r_s2_valid <= 1'b0;
      r_acc      <= '0;
    end else if (!stall) begin
      r_s1_op    <= in_valid ? vu_op_e'(op) : VU_OP_NOP;
      r_s1_sel   <= vu_sel_e'(sel);
      r_s1_valid <= in_valid;
      r_s1_opnd  <= w_opnd;
      r_s2_sel   <= r_s1_sel;
      r_s2_valid <= r_s1_valid;
      r_acc      <= w_acc_next;
    end
  end

  // Clear works through stalls; a same-edge overflow wins.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_ovf <= 1'b0;
    end else if (!stall && w_ovf_evt) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  vu_clamp16 u_clamp (
    .din  (r_acc[47:16]),
    .dout (w_clamp)
  );

  always_comb begin
    result = r_acc[15:0];
    case (r_s2_sel)
      VU_SEL_LO:       result = r_acc[15:0];
      VU_SEL_MID:      result = r_acc[31:16];
      VU_SEL_MIDCLAMP: result = w_clamp;
      VU_SEL_HI:       result = r_acc[47:32];
      default:         result = r_acc[15:0];
    endcase
  end

  assign out_valid = r_s2_valid;
  assign acc_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: doc/vu_acc_lane.md
# vu_acc_lane

Single-lane, 48-bit signed multiply-accumulate stage of the vector unit datapath. It accepts one 32-bit signed product per cycle from the lane multiplier, aligns it and adds it into the accumulator, or loads or subtracts it. Each cycle it presents a selected or clamped 16-bit slice of the accumulator. That 16-bit result feeds directly into the lane's 16-bit result register (dp_reg16) via `result`. Eight instances form the full vector unit, one per lane.

## Interface
Parameters:
- `ACC_W`, 48: accumulator width; fixed, not for override.

Ports (clock and reset first):
- `clk`  input  1  lane clock; all state on rising edge.
- `reset_l`  input  1  asynchronous active-low reset; asynchronous assert, synchronous-to-`clk` deassert handled upstream.
- `stall`  input  1  freeze every register, including the accumulator, for this cycle.
- `in_valid`  input  1  `op`, `product`, `align` and `sel` are meaningful this cycle.
- `op`  input  2  00 NOP, 01 LOAD, 10 ADD, 11 SUB.
- `product`  input  32  signed two's-complement multiplier output.
- `align`  input  1  0: product at acc[31:0]; 1: product at acc[47:16].
- `sel`  input  2  00 acc[15:0] raw, 01 acc[31:16] raw, 10 acc[47:16] clamped to s16, 11 acc[47:32] raw.
- `ovf_clr`  input  1  clear sticky overflow flag.
- `result`  output  16  selected accumulator slice.
- `out_valid`  output  1  `result` corresponds to a valid issued op.
- `acc_ovf`  output  1  sticky: a 48-bit signed overflow occurred on ADD or SUB.

## Operation
- Stage 1 (input register): on an unstalled edge, capture `op` (forced to NOP if `in_valid`=0), `sel`, `valid`, and the aligned operand. The aligned operand is `product` sign-extended to 48 bits, then left-shifted 16 if `align`=1.
- Stage 2 (accumulate): on an unstalled edge, apply the stage-1 op to the accumulator and capture stage-1 `sel`/`valid` into stage-2 registers.
  - LOAD: acc = operand.
  - ADD: acc = acc + operand.
  - SUB: acc = acc − operand.
  - NOP: acc unchanged.
- Output: `result` is combinational from acc and stage-2 `sel`; `out_valid` is the stage-2 valid register.
- Clamp (sel=10): if acc[47:31] are all equal, `result` = acc[31:16]. Otherwise `result` = 16'h8000 if acc[47]=1, else 16'h7FFF.
- Arithmetic is modular on 48 bits and wraps silently; no saturation of the accumulator itself.
- Overflow detection: `acc_ovf` sets when an ADD or SUB produces a 48-bit signed overflow, i.e. the operands' signs are equal (ADD) or differ (SUB) and the result sign differs from the old acc sign. LOAD and NOP never set it.
- Same edge: `acc_ovf` set has priority over `ovf_clr`. `ovf_clr` is honoured even during `stall`.
- Stall: all stage registers and acc hold; `result`/`out_valid` hold their values; inputs presented during stall are dropped (issue logic re-presents them).
- Bubble (`in_valid`=0) flows as NOP with valid=0; acc is untouched.

## Timing
- Latency: an op sampled at edge N updates acc at edge N+1. Its `result`/`out_valid` are visible after edge N+1, and dp_reg16 captures them at edge N+2.
- Throughput: one op per unstalled cycle; back-to-back ADDs see each other's results with no hazard, since the accumulate is single-cycle in stage 2.
- Reset (`reset_l`=0, any time, including mid-stream): acc = 0, both stage valids = 0, stage ops = NOP, stage sels = 00, `acc_ovf` = 0. Outputs are therefore `result` = 16'h0000, `out_valid` = 0, `acc_ovf` = 0.
- Ops in flight at reset are discarded; the first op after release behaves as on a fresh lane.

## Structure
- Shared package `vu_acc_pkg` contains:
  - `ACC_W` = 48;
  - op enum (`VU_OP_NOP`, `VU_OP_LOAD`, `VU_OP_ADD`, `VU_OP_SUB`);
  - sel enum (`VU_SEL_LO`, `VU_SEL_MID`, `VU_SEL_MIDCLAMP`, `VU_SEL_HI`).
- One sub-module, `vu_clamp16`: combinational 32-to-16 signed clamp of acc[47:16]. It is reused by the vector unit's other clamp points.
- No other hierarchy.

## Test plan
- Reset release: after `reset_l` rises, `result`=0000, `out_valid`=0, `acc_ovf`=0; a bubble stream keeps them there.
- LOAD/ADD chain: issue LOAD product=0x00001234 align=0, then ADD product=0x00000010 align=0, both with sel=00. Then `result` = 1234 at N+1 and 1244 at N+2, with `out_valid`=1 both cycles.
- Clamp:
  - LOAD product=0x7FFF0000, align=1 (acc=0x7FFF_0000_0000); sel=10 gives 7FFF and sel=11 gives 7FFF.
  - LOAD product=0x00010000, align=1 (acc=0x0001_0000_0000); sel=10 gives 7FFF.
  - LOAD product=0xFFFF8000, align=1 (acc=0xFFFF_8000_0000); sel=10 gives 8000.
- Overflow and wrap: LOAD product=0x7FFFFFFF align=1, then ADD the same. Result: acc wraps to 0xFFFF_FFFE_0000 and `acc_ovf`=1. Pulse `ovf_clr` alone and the flag clears; pulse `ovf_clr` together with an overflowing ADD and the flag stays 1.
- Stall: with an ADD in stage 1, hold `stall` for 3 cycles. During the stall acc, `result` and `out_valid` are unchanged and the input offered is dropped. The ADD completes one cycle after `stall` drops.
- Mid-stream reset: assert `reset_l`=0 asynchronously between edges during an ADD chain. Outputs go to 0 immediately; after release, a LOAD of 0x00000005 gives `result`=0005.
